// File: rtl/st_tx_arbiter_if.sv
// AXI-Stream style TX channel bundle (data, valid, last, byte enables, ready).
// master drives the payload and valid, slave returns ready.
interface st_tx_arbiter_if #(
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned KEEP_W = DATA_W / 8;

  logic [DATA_W-1:0] tdata;
  logic              tvld;
  logic              tlast;
  logic [KEEP_W-1:0] tkeep;
  logic              trdy;

  modport master (output tdata, output tvld, output tlast, output tkeep, input  trdy);
  modport slave  (input  tdata, input  tvld, input  tlast, input  tkeep, output trdy);
endinterface

// File: rtl/st_tx_arbiter.sv
// Packet-level round-robin arbiter merging sd/au/arp TX streams into the TSE MAC port.
// Optional macro ST_TX_ARB_ARP_PRIO_EN gives ARP strict priority at each arbitration.
module st_tx_arbiter #(
  parameter int unsigned DATA_W = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  st_tx_arbiter_if.slave  sd,
  st_tx_arbiter_if.slave  au,
  st_tx_arbiter_if.slave  arp,
  st_tx_arbiter_if.master to_tse,
  output logic [2:0]      grant_o,
  output logic            busy_o
);
  localparam int unsigned KEEP_W = DATA_W / 8;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [1:0] last_ptr_q, last_ptr_d;
  logic [2:0] req;
  logic [1:0] grant_idx;

  assign req = {arp.tvld, au.tvld, sd.tvld};

  // Next source to serve: first requester after the last granted one.
  function automatic logic [2:0] pick(input logic [2:0] r, input logic [1:0] last);
    logic [2:0] g;
    g = 3'b000;
`ifdef ST_TX_ARB_ARP_PRIO_EN
    if (r[2]) begin
      g = 3'b100;
    end else if (last == 2'd0) begin
      if (r[1])      g = 3'b010;
      else if (r[0]) g = 3'b001;
    end else begin
      if (r[0])      g = 3'b001;
      else if (r[1]) g = 3'b010;
    end
`else
    case (last)
      2'd0: begin
        if (r[1])      g = 3'b010;
        else if (r[2]) g = 3'b100;
        else if (r[0]) g = 3'b001;
      end
      2'd1: begin
        if (r[2])      g = 3'b100;
        else if (r[0]) g = 3'b001;
        else if (r[1]) g = 3'b010;
      end
      default: begin
        if (r[0])      g = 3'b001;
        else if (r[1]) g = 3'b010;
        else if (r[2]) g = 3'b100;
      end
    endcase
`endif
    return g;
  endfunction

  assign grant_idx = grant_q[2] ? 2'd2 : (grant_q[1] ? 2'd1 : 2'd0);

  // State, grant and rotation pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_q    <= 3'b000;
      last_ptr_q <= 2'd2;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_ptr_q <= last_ptr_d;
    end
  end

  // Arbitration, zero-latency datapath mux and packet-end detection.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_ptr_d    = last_ptr_q;
    to_tse.tdata  = DATA_W'(0);
    to_tse.tkeep  = KEEP_W'(0);
    to_tse.tlast  = 1'b0;
    to_tse.tvld   = 1'b0;
    sd.trdy       = 1'b0;
    au.trdy       = 1'b0;
    arp.trdy      = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = pick(req, last_ptr_q);
          state_d = XFER;
        end
      end
      XFER: begin
        if (grant_q[0]) begin
          to_tse.tdata = sd.tdata;
          to_tse.tkeep = sd.tkeep;
          to_tse.tlast = sd.tlast;
          to_tse.tvld  = sd.tvld;
          sd.trdy      = to_tse.trdy;
        end else if (grant_q[1]) begin
          to_tse.tdata = au.tdata;
          to_tse.tkeep = au.tkeep;
          to_tse.tlast = au.tlast;
          to_tse.tvld  = au.tvld;
          au.trdy      = to_tse.trdy;
        end else if (grant_q[2]) begin
          to_tse.tdata = arp.tdata;
          to_tse.tkeep = arp.tkeep;
          to_tse.tlast = arp.tlast;
          to_tse.tvld  = arp.tvld;
          arp.trdy     = to_tse.trdy;
        end
        // Grant is released only on the tlast handshake.
        if (to_tse.tvld && to_tse.trdy && to_tse.tlast) begin
          state_d    = IDLE;
          grant_d    = 3'b000;
          last_ptr_d = grant_idx;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 3'b000;
      end
    endcase
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q == XFER);

endmodule

// File: tb/tb_st_tx_arbiter.sv
// Bench for st_tx_arbiter: directed vector table, hand-written corner sequences,
// then random traffic checked against a packet-level round-robin reference model.
module tb_st_tx_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  st_tx_arbiter_if #(.DATA_W(32)) sd_if ();
  st_tx_arbiter_if #(.DATA_W(32)) au_if ();
  st_tx_arbiter_if #(.DATA_W(32)) arp_if ();
  st_tx_arbiter_if #(.DATA_W(32)) tse_if ();
  logic [2:0] grant;
  logic       busy;

  st_tx_arbiter #(.DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .sd(sd_if.slave), .au(au_if.slave), .arp(arp_if.slave),
    .to_tse(tse_if.master), .grant_o(grant), .busy_o(busy)
  );

  // Source-side stimulus, index 0 = sd, 1 = au, 2 = arp
  logic [2:0]  s_vld = 3'b000;
  logic [2:0]  s_last = 3'b000;
  logic [31:0] s_data [3];
  logic [3:0]  s_keep [3];
  logic [2:0]  s_rdy;
  logic        tse_rdy = 1'b0;

  assign sd_if.tvld  = s_vld[0];  assign sd_if.tlast  = s_last[0];
  assign sd_if.tdata = s_data[0]; assign sd_if.tkeep  = s_keep[0];
  assign au_if.tvld  = s_vld[1];  assign au_if.tlast  = s_last[1];
  assign au_if.tdata = s_data[1]; assign au_if.tkeep  = s_keep[1];
  assign arp_if.tvld = s_vld[2];  assign arp_if.tlast = s_last[2];
  assign arp_if.tdata = s_data[2]; assign arp_if.tkeep = s_keep[2];
  assign s_rdy = {arp_if.trdy, au_if.trdy, sd_if.trdy};
  assign tse_if.trdy = tse_rdy;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_all(input string nm, input logic [2:0] e_gnt, input logic e_busy,
                           input logic e_tvld, input logic [31:0] e_d, input logic e_l,
                           input logic [3:0] e_k, input logic [2:0] e_rdy, input bit chk_data);
    chk({nm, " grant"}, 32'(grant), 32'(e_gnt));
    chk({nm, " busy"},  32'(busy), 32'(e_busy));
    chk({nm, " tvld"},  32'(tse_if.tvld), 32'(e_tvld));
    chk({nm, " trdy"},  32'(s_rdy), 32'(e_rdy));
    if (chk_data) begin
      chk({nm, " tdata"}, tse_if.tdata, e_d);
      chk({nm, " tlast"}, 32'(tse_if.tlast), 32'(e_l));
      chk({nm, " tkeep"}, 32'(tse_if.tkeep), 32'(e_k));
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [2:0] l, input logic [31:0] d0,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [3:0] k0,
                       input logic r);
    s_vld = v; s_last = l;
    s_data[0] = d0; s_data[1] = d1; s_data[2] = d2;
    s_keep[0] = k0; s_keep[1] = 4'hF; s_keep[2] = 4'hF;
    tse_rdy = r;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    drive(3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0]  vld;
    logic [31:0] sd_d, au_d, arp_d;
    logic [2:0]  lst;
    logic [3:0]  sd_k;
    logic        rdy;
    logic [2:0]  e_gnt;
    logic        e_busy, e_tvld;
    logic [31:0] e_d;
    logic        e_l;
    logic [3:0]  e_k;
    logic [2:0]  e_rdy;
  } vec_t;

  vec_t tbl [16];

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t mem [3][64];
  int    wr [3];
  int    rd [3];

  initial begin
    int owner, last, beats_out, total_beats;
    logic [2:0] hs, er;
    bit done;

    // Directed vectors: sd 4-beat, au 3-beat with trdy 1,0,0,1,1, then arp and sd.
    tbl[0]  = '{3'b011, 32'h11111111, 32'hA1A1A1A1, 32'h0, 3'b000, 4'hF, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 3'b000};
    tbl[1]  = '{3'b011, 32'h11111111, 32'hA1A1A1A1, 32'h0, 3'b000, 4'hF, 1'b1, 3'b001, 1'b1, 1'b1, 32'h11111111, 1'b0, 4'hF, 3'b001};
    tbl[2]  = '{3'b011, 32'h22222222, 32'hA1A1A1A1, 32'h0, 3'b000, 4'hF, 1'b1, 3'b001, 1'b1, 1'b1, 32'h22222222, 1'b0, 4'hF, 3'b001};
    tbl[3]  = '{3'b011, 32'h33333333, 32'hA1A1A1A1, 32'h0, 3'b000, 4'hF, 1'b1, 3'b001, 1'b1, 1'b1, 32'h33333333, 1'b0, 4'hF, 3'b001};
    tbl[4]  = '{3'b011, 32'h44444444, 32'hA1A1A1A1, 32'h0, 3'b001, 4'h3, 1'b1, 3'b001, 1'b1, 1'b1, 32'h44444444, 1'b1, 4'h3, 3'b001};
    tbl[5]  = '{3'b010, 32'h0, 32'hA1A1A1A1, 32'h0, 3'b000, 4'hF, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 3'b000};
    tbl[6]  = '{3'b010, 32'h0, 32'hA1A1A1A1, 32'h0, 3'b000, 4'hF, 1'b1, 3'b010, 1'b1, 1'b1, 32'hA1A1A1A1, 1'b0, 4'hF, 3'b010};
    tbl[7]  = '{3'b010, 32'h0, 32'hA2A2A2A2, 32'h0, 3'b000, 4'hF, 1'b0, 3'b010, 1'b1, 1'b1, 32'hA2A2A2A2, 1'b0, 4'hF, 3'b000};
    tbl[8]  = '{3'b010, 32'h0, 32'hA2A2A2A2, 32'h0, 3'b000, 4'hF, 1'b0, 3'b010, 1'b1, 1'b1, 32'hA2A2A2A2, 1'b0, 4'hF, 3'b000};
    tbl[9]  = '{3'b010, 32'h0, 32'hA2A2A2A2, 32'h0, 3'b000, 4'hF, 1'b1, 3'b010, 1'b1, 1'b1, 32'hA2A2A2A2, 1'b0, 4'hF, 3'b010};
    tbl[10] = '{3'b111, 32'h55555555, 32'hA3A3A3A3, 32'hC1C1C1C1, 3'b111, 4'hF, 1'b1, 3'b010, 1'b1, 1'b1, 32'hA3A3A3A3, 1'b1, 4'hF, 3'b010};
    tbl[11] = '{3'b101, 32'h55555555, 32'h0, 32'hC1C1C1C1, 3'b101, 4'hF, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 3'b000};
    tbl[12] = '{3'b101, 32'h55555555, 32'h0, 32'hC1C1C1C1, 3'b101, 4'hF, 1'b1, 3'b100, 1'b1, 1'b1, 32'hC1C1C1C1, 1'b1, 4'hF, 3'b100};
    tbl[13] = '{3'b001, 32'h55555555, 32'h0, 32'h0, 3'b001, 4'hF, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 3'b000};
    tbl[14] = '{3'b001, 32'h55555555, 32'h0, 32'h0, 3'b001, 4'hF, 1'b1, 3'b001, 1'b1, 1'b1, 32'h55555555, 1'b1, 4'hF, 3'b001};
    tbl[15] = '{3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 4'hF, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 3'b000};

    drive(3'b111, 3'b111, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 4'hF, 1'b1);
    #2;
    check_all("in_reset", 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 3'b000, 1'b1);
    do_reset();

    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      drive(tbl[i].vld, tbl[i].lst, tbl[i].sd_d, tbl[i].au_d, tbl[i].arp_d, tbl[i].sd_k, tbl[i].rdy);
      @(negedge clk);
      check_all($sformatf("row%0d", i), tbl[i].e_gnt, tbl[i].e_busy, tbl[i].e_tvld,
                tbl[i].e_d, tbl[i].e_l, tbl[i].e_k, tbl[i].e_rdy, 1'b1);
    end

    // sd bubbles for two cycles mid-packet while au waits.
    do_reset();
    @(posedge clk); #1; drive(3'b011, 3'b010, 32'hD1, 32'hAA, 32'h0, 4'hF, 1'b1);
    @(negedge clk); check_all("bub0", 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 3'b000, 1'b1);
    @(posedge clk); #1;
    @(negedge clk); check_all("bub1", 3'b001, 1'b1, 1'b1, 32'hD1, 1'b0, 4'hF, 3'b001, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1; drive(3'b010, 3'b010, 32'h0, 32'hAA, 32'h0, 4'hF, 1'b1);
      @(negedge clk); check_all($sformatf("bubgap%0d", i), 3'b001, 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 3'b001, 1'b0);
    end
    @(posedge clk); #1; drive(3'b011, 3'b011, 32'hD2, 32'hAA, 32'h0, 4'h1, 1'b1);
    @(negedge clk); check_all("bub4", 3'b001, 1'b1, 1'b1, 32'hD2, 1'b1, 4'h1, 3'b001, 1'b1);
    @(posedge clk); #1; drive(3'b010, 3'b010, 32'h0, 32'hAA, 32'h0, 4'hF, 1'b1);
    @(negedge clk); check_all("bub5", 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 3'b000, 1'b1);
    @(posedge clk); #1;
    @(negedge clk); check_all("bub6", 3'b010, 1'b1, 1'b1, 32'hAA, 1'b1, 4'hF, 3'b010, 1'b1);
    @(posedge clk); #1; drive(3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 4'hF, 1'b1);
    @(negedge clk); check_all("bub7", 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 3'b000, 1'b1);

    // Reset during beat 2 of an arp packet.
    do_reset();
    @(posedge clk); #1; drive(3'b100, 3'b000, 32'h0, 32'h0, 32'hC0DE0001, 4'hF, 1'b1);
    @(negedge clk); check_all("rst0", 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 3'b000, 1'b1);
    @(posedge clk); #1;
    @(negedge clk); check_all("rst1", 3'b100, 1'b1, 1'b1, 32'hC0DE0001, 1'b0, 4'hF, 3'b100, 1'b1);
    @(posedge clk); #1; drive(3'b100, 3'b000, 32'h0, 32'h0, 32'hC0DE0002, 4'hF, 1'b1);
    #1; chk("rst2 pre tdata", tse_if.tdata, 32'hC0DE0002);
    #1; reset_n = 1'b0;
    #1; check_all("rst2", 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 3'b000, 1'b1);
    @(negedge clk); drive(3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 4'hF, 1'b1);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1; drive(3'b111, 3'b111, 32'h5D, 32'hA0, 32'hC0, 4'hF, 1'b1);
    @(negedge clk); check_all("rst3", 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 3'b000, 1'b1);
    @(posedge clk); #1;
    @(negedge clk); check_all("rst4", 3'b001, 1'b1, 1'b1, 32'h5D, 1'b1, 4'hF, 3'b001, 1'b1);

    // Random traffic against a packet-level reference model.
    do_reset();
    total_beats = 0;
    for (int s = 0; s < 3; s++) begin
      wr[s] = 0; rd[s] = 0;
      for (int p = 0; p < 12; p++) begin
        int len;
        len = int'($urandom_range(4, 1));
        for (int b = 0; b < len; b++) begin
          mem[s][wr[s]].d = $urandom();
          mem[s][wr[s]].k = (b == len - 1) ? 4'($urandom_range(15, 1)) : 4'hF;
          mem[s][wr[s]].l = (b == len - 1);
          wr[s]++;
          total_beats++;
        end
      end
    end
    owner = -1; last = 2; hs = 3'b000; beats_out = 0; done = 1'b0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(posedge clk); #1;
      for (int s = 0; s < 3; s++) begin
        if (hs[s]) rd[s]++;
        if (!(s_vld[s] && !hs[s])) begin
          if (rd[s] < wr[s] && $urandom_range(3) != 0) begin
            s_vld[s] = 1'b1; s_data[s] = mem[s][rd[s]].d;
            s_keep[s] = mem[s][rd[s]].k; s_last[s] = mem[s][rd[s]].l;
          end else begin
            s_vld[s] = 1'b0; s_data[s] = 32'h0; s_keep[s] = 4'h0; s_last[s] = 1'b0;
          end
        end
      end
      tse_rdy = ($urandom_range(3) != 0);
      @(negedge clk);
      if (owner < 0) begin
        check_all("rnd idle", 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 3'b000, 1'b1);
      end else begin
        er = 3'b000; er[owner] = tse_rdy;
        check_all("rnd xfer", 3'b001 << owner, 1'b1, s_vld[owner], 32'h0, 1'b0, 4'h0, er, 1'b0);
        if (s_vld[owner] && tse_rdy) begin
          chk("rnd tdata", tse_if.tdata, mem[owner][rd[owner]].d);
          chk("rnd tkeep", 32'(tse_if.tkeep), 32'(mem[owner][rd[owner]].k));
          chk("rnd tlast", 32'(tse_if.tlast), 32'(mem[owner][rd[owner]].l));
          beats_out++;
        end
      end
      hs = s_vld & s_rdy;
      // Model: whole packets, rotating from the source after the last one served.
      if (owner < 0) begin
`ifdef ST_TX_ARB_ARP_PRIO_EN
        if (s_vld[2]) owner = 2;
        else
          for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (last + k) % 3;
            if (owner < 0 && idx != 2 && s_vld[idx]) owner = idx;
          end
`else
        for (int k = 1; k <= 3; k++) begin
          int idx;
          idx = (last + k) % 3;
          if (owner < 0 && s_vld[idx]) owner = idx;
        end
`endif
      end else if (s_vld[owner] && tse_rdy && mem[owner][rd[owner]].l) begin
        last = owner;
        owner = -1;
      end
      if (owner < 0 && rd[0] + int'(hs[0]) == wr[0] && rd[1] + int'(hs[1]) == wr[1]
          && rd[2] + int'(hs[2]) == wr[2]) done = 1'b1;
    end
    chk("rnd drained", 32'(done), 32'd1);
    chk("rnd beats", 32'(beats_out), 32'(total_beats));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
